// File: rtl/master_in.sv
// Master-side serial receive path: handshakes a read with the slave, deserialises one byte or a
// burst of bytes MSB first, strobes each completed byte and flags the end of the transaction.
module master_in (
  input  logic        clk,
  input  logic        reset,
  input  logic        slave_valid,
  input  logic        rx_data,
  input  logic [11:0] burst_num,
  input  logic [1:0]  instruction,
  output logic        rx_done,
  output logic        master_ready,
  output logic        new_rx,
  output logic [7:0]  data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [1:0] InstrRead = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [11:0] total_q, total_d;

  logic        handshake;
  logic [7:0]  shift_next;
  logic [11:0] byte_cnt_inc;

  // Moore outputs, plus the ready term which also depends on the current command.
  always_comb begin
    master_ready = (state_q == StIdle) && (instruction == InstrRead);
    new_rx       = (state_q == StGap) || (state_q == StDone);
    rx_done      = (state_q == StDone);
    data         = data_q;
  end

  // Next-state logic for the receive sequencer and its datapath.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    data_d       = data_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    total_d      = total_q;
    handshake    = master_ready && slave_valid;
    shift_next   = {shift_q[6:0], rx_data};
    byte_cnt_inc = byte_cnt_q + 12'd1;

    case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d    = StRecv;
          // A burst count of 0 still moves one byte.
          total_d    = (burst_num == 12'd0) ? 12'd1 : burst_num;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 12'd0;
          shift_d    = 8'h00;
        end
      end
      StRecv: begin
        shift_d   = shift_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_d     = shift_next;
          byte_cnt_d = byte_cnt_inc;
          state_d    = (byte_cnt_inc < total_q) ? StGap : StDone;
        end
      end
      StGap: begin
        // The line is ignored for one slot; slave_valid is not rechecked inside a burst.
        bit_cnt_d = 3'd0;
        state_d   = StRecv;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset; a partial byte is simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 12'd0;
      total_q    <= 12'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      total_q    <= total_d;
    end
  end

endmodule

// File: tb/tb_master_in.sv
// Scoreboard bench for master_in: the driver pushes expected bytes, a monitor checks each strobe.
module tb_master_in;

  logic        clk;
  logic        rst_n;
  logic        slave_valid;
  logic        rx_data;
  logic [11:0] burst_num;
  logic [1:0]  instruction;
  logic        rx_done;
  logic        master_ready;
  logic        new_rx;
  logic [7:0]  data;

  master_in dut (
    .clk          (clk),
    .reset        (rst_n),
    .slave_valid  (slave_valid),
    .rx_data      (rx_data),
    .burst_num    (burst_num),
    .instruction  (instruction),
    .rx_done      (rx_done),
    .master_ready (master_ready),
    .new_rx       (new_rx),
    .data         (data)
  );

  typedef struct {
    logic [7:0] byte_v;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] stim [0:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected byte, its flag and its cycle.
  always @(negedge clk) begin
    if (rst_n && new_rx) begin
      if (sb_q.size() == 0) begin
        check("unexpected_new_rx", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rx_byte", int'(data), int'(e.byte_v));
        check("rx_done_flag", int'(rx_done), int'(e.last));
        check("rx_cycle", cyc, e.cyc);
      end
    end else if (rst_n && rx_done) begin
      check("rx_done_without_new_rx", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction of t bytes from stim[]; optionally disturbs inputs during byte 1.
  task automatic run_txn(input int t, input logic [11:0] bn, input bit disturb);
    int h;
    @(negedge clk);
    instruction = 2'b11;
    burst_num   = bn;
    slave_valid = 1'b1;
    #1;
    check("ready_before_h", int'(master_ready), 1);
    tick();
    h = cyc;
    slave_valid = 1'b0;
    for (int k = 0; k < t; k++) begin
      sb_q.push_back('{byte_v: stim[k], last: (k == t - 1), cyc: h + 8 + 9 * k});
      for (int b = 7; b >= 0; b--) begin
        logic [7:0] cur;
        cur = stim[k];
        rx_data = cur[b];
        if (disturb && k == 1 && b == 4) begin
          burst_num   = 12'd1;
          instruction = 2'b00;
        end
        tick();
        if (b != 0) check("ready_low_recv", int'(master_ready), 0);
      end
      // Inter-byte gap, or the completion cycle after the last byte.
      rx_data = ~rx_data;
      tick();
    end
    check("ready_cycle", cyc, h + 9 * t);
    check("ready_after_txn", int'(master_ready), int'(instruction == 2'b11));
    check("data_hold", int'(data), int'(stim[t - 1]));
  endtask

  initial begin
    rst_n       = 1'b0;
    slave_valid = 1'b0;
    rx_data     = 1'b0;
    burst_num   = 12'd0;
    instruction = 2'b00;

    // Reset state, with ready tracking the command while held in reset.
    repeat (3) tick();
    check("rst_data", int'(data), 0);
    check("rst_new_rx", int'(new_rx), 0);
    check("rst_rx_done", int'(rx_done), 0);
    check("rst_ready_noread", int'(master_ready), 0);
    instruction = 2'b11;
    #1;
    check("rst_ready_read", int'(master_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single read, burst_num 0 means one byte.
    stim[0] = 8'h6B;
    run_txn(1, 12'd0, 1'b0);

    // Burst of three.
    stim[0] = 8'h7A;
    stim[1] = 8'h2B;
    stim[2] = 8'h7B;
    run_txn(3, 12'd3, 1'b0);

    // No read command: nothing may start.
    @(negedge clk);
    instruction = 2'b01;
    slave_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("noread_ready", int'(master_ready), 0);
      check("noread_data", int'(data), 8'h7B);
    end
    slave_valid = 1'b0;

    // Reset after four bits of a byte: it is discarded.
    @(negedge clk);
    instruction = 2'b11;
    slave_valid = 1'b1;
    tick();
    slave_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rx_data = b[0];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_data", int'(data), 0);
    check("midrst_new_rx", int'(new_rx), 0);
    check("midrst_ready", int'(master_ready), 1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    stim[0] = 8'hA5;
    run_txn(1, 12'd1, 1'b0);

    // Command and count changed mid-burst are ignored until IDLE.
    stim[0] = 8'hC3;
    stim[1] = 8'h18;
    stim[2] = 8'hE7;
    run_txn(3, 12'd3, 1'b1);

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
